// File: rtl/mips_exec_core_pkg.sv
// Shared types and constants for the multicycle MIPS execution core.
// Holds the state encoding, opcode/funct encodings and datapath mux selects.
package codes;

  typedef logic [31:0] size_t;
  typedef logic [4:0]  regaddr_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    MEM   = 2'd2,
    HALT  = 2'd3
  } state_t;

  typedef enum logic [5:0] {
    OP_SPECIAL = 6'h00,
    OP_ADDIU   = 6'h09,
    OP_SLTI    = 6'h0A,
    OP_SLTIU   = 6'h0B,
    OP_ANDI    = 6'h0C,
    OP_ORI     = 6'h0D,
    OP_XORI    = 6'h0E,
    OP_LUI     = 6'h0F,
    OP_LW      = 6'h23,
    OP_SW      = 6'h2B
  } opcode_t;

  typedef enum logic [5:0] {
    FN_SLL   = 6'h00,
    FN_SRL   = 6'h02,
    FN_SRA   = 6'h03,
    FN_SLLV  = 6'h04,
    FN_SRLV  = 6'h06,
    FN_SRAV  = 6'h07,
    FN_JR    = 6'h08,
    FN_MFHI  = 6'h10,
    FN_MTHI  = 6'h11,
    FN_MFLO  = 6'h12,
    FN_MTLO  = 6'h13,
    FN_MULT  = 6'h18,
    FN_MULTU = 6'h19,
    FN_ADDU  = 6'h21,
    FN_SUBU  = 6'h23,
    FN_AND   = 6'h24,
    FN_OR    = 6'h25,
    FN_XOR   = 6'h26,
    FN_NOR   = 6'h27,
    FN_SLT   = 6'h2A,
    FN_SLTU  = 6'h2B
  } func_t;

  localparam logic REGFILE_ADDR_SEL_RD = 1'b0;
  localparam logic REGFILE_ADDR_SEL_RT = 1'b1;
  localparam logic SRC_B_SEL_RT        = 1'b0;
  localparam logic SRC_B_SEL_IMM       = 1'b1;

  // Sign-extend a 16-bit immediate to the word width.
  function automatic size_t sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/mips_exec_core_fsm.sv
// State sequencer of the multicycle MIPS core: FETCH -> EXEC -> (MEM) -> FETCH,
// with a terminal HALT entered from FETCH when the PC reaches zero.
// With DEBUG_EN defined, entering HALT is reported in simulation.
module mips_exec_core_fsm
  import codes::*;
(
  input  logic   clk,
  input  logic   reset_i,
  input  logic   halt,
  input  logic   stall,
  input  logic   is_lw,
  output state_t state
);

  state_t next_state;

  // Next-state logic; a bus stall freezes the sequencer in place.
  always_comb begin
    next_state = state;
    if (!stall) begin
      case (state)
        FETCH:   next_state = halt ? HALT : EXEC;
        EXEC:    next_state = is_lw ? MEM : FETCH;
        MEM:     next_state = FETCH;
        HALT:    next_state = HALT;
        default: next_state = FETCH;
      endcase
    end
  end

  // State register with synchronous reset back to FETCH.
  always_ff @(posedge clk) begin
    if (reset_i) state <= FETCH;
    else         state <= next_state;
  end

`ifdef DEBUG_EN
  // Report the transition into HALT once.
  always_ff @(posedge clk) begin
    if (!reset_i && state != HALT && next_state == HALT)
      $display("[mips_exec_core] entering HALT at %0t", $time);
  end
`endif

endmodule

// File: rtl/mips_exec_core.sv
// Execution/control core of the multicycle MIPS CPU: instruction decode,
// datapath/Avalon enables, ALU and HI/LO registers around the fsm sequencer.
// Optional feature macro: DEBUG_EN (fatal on unknown instructions in EXEC).
module mips_exec_core
  import codes::*;
(
  input  logic        clk,
  input  logic        reset_i,
  input  logic        halt_i,
  input  logic        stall_i,
  input  logic [5:0]  opcode_i,
  input  logic [5:0]  funct_i,
  input  logic [15:0] immediate_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  input  logic [31:0] ram_readdata_i,
  output logic [1:0]  state_o,
  output logic        pc_write_en_o,
  output logic        ir_write_en_o,
  output logic        regfile_write_en_o,
  output logic        ram_read_en_o,
  output logic        ram_write_en_o,
  output logic [3:0]  ram_byte_en_o,
  output logic        ram_addr_sel_o,
  output logic        src_b_sel_o,
  output logic        regfile_addr_3_sel_o,
  output logic [31:0] rd_o,
  output logic [31:0] rt_o,
  output logic [31:0] effective_address_o,
  output logic        b_cond_met_o,
  output logic [31:0] mfhi_o,
  output logic [31:0] mflo_o
);

  state_t      state;
  size_t       hi, lo;
  size_t       r_result, i_result, imm_sext, imm_zext;
  logic [4:0]  shamt;
  logic [63:0] prod_signed, prod_unsigned;
  logic        is_r_alu, is_hilo, is_i_alu, is_lw, is_sw, is_jr;

  mips_exec_core_fsm u_fsm (
    .clk     (clk),
    .reset_i (reset_i),
    .halt    (halt_i),
    .stall   (stall_i),
    .is_lw   (is_lw),
    .state   (state)
  );

  assign state_o             = state;
  assign shamt               = immediate_i[10:6];
  assign imm_sext            = sext16(immediate_i);
  assign imm_zext            = {16'h0000, immediate_i};
  assign effective_address_o = rs_i + imm_sext;
  assign prod_signed         = {{32{rs_i[31]}}, rs_i} * {{32{rt_i[31]}}, rt_i};
  assign prod_unsigned       = {32'h0, rs_i} * {32'h0, rt_i};
  assign mfhi_o              = hi;
  assign mflo_o              = lo;

  // Decode the instruction class and compute the R-type and I-type results.
  always_comb begin
    is_r_alu = 1'b0;
    is_hilo  = 1'b0;
    is_i_alu = 1'b0;
    is_lw    = 1'b0;
    is_sw    = 1'b0;
    is_jr    = 1'b0;
    r_result = '0;
    i_result = '0;
    case (opcode_i)
      OP_SPECIAL: begin
        is_r_alu = 1'b1;
        case (funct_i)
          FN_SLL:   r_result = rt_i << shamt;
          FN_SRL:   r_result = rt_i >> shamt;
          FN_SRA:   r_result = $signed(rt_i) >>> shamt;
          FN_SLLV:  r_result = rt_i << rs_i[4:0];
          FN_SRLV:  r_result = rt_i >> rs_i[4:0];
          FN_SRAV:  r_result = $signed(rt_i) >>> rs_i[4:0];
          FN_MFHI:  r_result = hi;
          FN_MFLO:  r_result = lo;
          FN_ADDU:  r_result = rs_i + rt_i;
          FN_SUBU:  r_result = rs_i - rt_i;
          FN_AND:   r_result = rs_i & rt_i;
          FN_OR:    r_result = rs_i | rt_i;
          FN_XOR:   r_result = rs_i ^ rt_i;
          FN_NOR:   r_result = ~(rs_i | rt_i);
          FN_SLT:   r_result = {31'b0, $signed(rs_i) < $signed(rt_i)};
          FN_SLTU:  r_result = {31'b0, rs_i < rt_i};
          FN_JR: begin
            is_r_alu = 1'b0;
            is_jr    = 1'b1;
          end
          FN_MTHI, FN_MTLO, FN_MULT, FN_MULTU: begin
            is_r_alu = 1'b0;
            is_hilo  = 1'b1;
          end
          default:  is_r_alu = 1'b0;
        endcase
      end
      OP_ADDIU: begin is_i_alu = 1'b1; i_result = rs_i + imm_sext; end
      OP_SLTI:  begin is_i_alu = 1'b1; i_result = {31'b0, $signed(rs_i) < $signed(imm_sext)}; end
      OP_SLTIU: begin is_i_alu = 1'b1; i_result = {31'b0, rs_i < imm_sext}; end
      OP_ANDI:  begin is_i_alu = 1'b1; i_result = rs_i & imm_zext; end
      OP_ORI:   begin is_i_alu = 1'b1; i_result = rs_i | imm_zext; end
      OP_XORI:  begin is_i_alu = 1'b1; i_result = rs_i ^ imm_zext; end
      OP_LUI:   begin is_i_alu = 1'b1; i_result = {immediate_i, 16'h0000}; end
      OP_LW:    is_lw = 1'b1;
      OP_SW:    is_sw = 1'b1;
      default:  ;
    endcase
  end

  // Control outputs per state; stall masks the write enables but keeps the bus request.
  always_comb begin
    pc_write_en_o        = 1'b0;
    ir_write_en_o        = 1'b0;
    regfile_write_en_o   = 1'b0;
    ram_read_en_o        = 1'b0;
    ram_write_en_o       = 1'b0;
    ram_byte_en_o        = 4'b0000;
    ram_addr_sel_o       = 1'b0;
    src_b_sel_o          = SRC_B_SEL_RT;
    regfile_addr_3_sel_o = REGFILE_ADDR_SEL_RD;
    b_cond_met_o         = 1'b0;
    rd_o                 = r_result;
    rt_o                 = rt_i;
    case (state)
      FETCH: begin
        if (!halt_i) begin
          ram_read_en_o = 1'b1;
          ram_byte_en_o = 4'b1111;
          ir_write_en_o = !stall_i;
        end
      end
      EXEC: begin
        pc_write_en_o = !stall_i;
        if (is_r_alu) begin
          regfile_write_en_o   = !stall_i;
          regfile_addr_3_sel_o = REGFILE_ADDR_SEL_RD;
        end
        if (is_i_alu) begin
          regfile_write_en_o   = !stall_i;
          regfile_addr_3_sel_o = REGFILE_ADDR_SEL_RT;
          src_b_sel_o          = SRC_B_SEL_IMM;
          rt_o                 = i_result;
        end
        if (is_lw) begin
          ram_read_en_o  = 1'b1;
          ram_addr_sel_o = 1'b1;
          ram_byte_en_o  = 4'b1111;
        end
        if (is_sw) begin
          ram_write_en_o = 1'b1;
          ram_addr_sel_o = 1'b1;
          ram_byte_en_o  = 4'b1111;
        end
        b_cond_met_o = is_jr;
      end
      MEM: begin
        regfile_write_en_o   = !stall_i;
        regfile_addr_3_sel_o = REGFILE_ADDR_SEL_RT;
        rt_o                 = ram_readdata_i;
      end
      default: ;
    endcase
  end

  // HI/LO registers update on the edge that ends EXEC for MTHI/MTLO/MULT/MULTU.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      hi <= '0;
      lo <= '0;
    end else if (state == EXEC && !stall_i && is_hilo) begin
      case (funct_i)
        FN_MTHI:  hi <= rs_i;
        FN_MTLO:  lo <= rs_i;
        FN_MULT:  begin hi <= prod_signed[63:32];   lo <= prod_signed[31:0];   end
        FN_MULTU: begin hi <= prod_unsigned[63:32]; lo <= prod_unsigned[31:0]; end
        default:  ;
      endcase
    end
  end

`ifdef DEBUG_EN
  // Stop simulation on an instruction the decoder does not recognise.
  always_ff @(posedge clk) begin
    if (!reset_i && state == EXEC && !stall_i &&
        !(is_r_alu || is_hilo || is_i_alu || is_lw || is_sw || is_jr))
      $fatal(1, "[mips_exec_core] unknown instruction opcode=%h funct=%h", opcode_i, funct_i);
  end
`endif

endmodule

// File: tb/tb_mips_exec_core.sv
// Self-checking bench for mips_exec_core: table of single-instruction vectors
// through a scoreboard queue, plus hand-written reset/LW/stall/SW/JR/HALT sequences.
module tb_mips_exec_core;

  logic        clk = 1'b0;
  logic        reset_i, halt_i, stall_i;
  logic [5:0]  opcode_i, funct_i;
  logic [15:0] immediate_i;
  logic [31:0] rs_i, rt_i, ram_readdata_i;
  logic [1:0]  state_o;
  logic        pc_write_en_o, ir_write_en_o, regfile_write_en_o;
  logic        ram_read_en_o, ram_write_en_o, ram_addr_sel_o, src_b_sel_o;
  logic        regfile_addr_3_sel_o, b_cond_met_o;
  logic [3:0]  ram_byte_en_o;
  logic [31:0] rd_o, rt_o, effective_address_o, mfhi_o, mflo_o;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [15:0] imm;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        we;
    logic        sel;
    logic        chk_rd;
    logic [31:0] rd;
    logic        chk_rt;
    logic [31:0] rtv;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  mips_exec_core dut (
    .clk(clk), .reset_i(reset_i), .halt_i(halt_i), .stall_i(stall_i),
    .opcode_i(opcode_i), .funct_i(funct_i), .immediate_i(immediate_i),
    .rs_i(rs_i), .rt_i(rt_i), .ram_readdata_i(ram_readdata_i),
    .state_o(state_o), .pc_write_en_o(pc_write_en_o), .ir_write_en_o(ir_write_en_o),
    .regfile_write_en_o(regfile_write_en_o), .ram_read_en_o(ram_read_en_o),
    .ram_write_en_o(ram_write_en_o), .ram_byte_en_o(ram_byte_en_o),
    .ram_addr_sel_o(ram_addr_sel_o), .src_b_sel_o(src_b_sel_o),
    .regfile_addr_3_sel_o(regfile_addr_3_sel_o), .rd_o(rd_o), .rt_o(rt_o),
    .effective_address_o(effective_address_o), .b_cond_met_o(b_cond_met_o),
    .mfhi_o(mfhi_o), .mflo_o(mflo_o)
  );

  always #5 clk = ~clk;

  // Abort a runaway simulation.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    opcode_i    = v.op;
    funct_i     = v.fn;
    immediate_i = v.imm;
    rs_i        = v.rs;
    rt_i        = v.rt;
    exp_q.push_back(v);
  endtask

  task automatic checkOutput();
    vec_t e;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check({e.name, "_state"}, 32'(state_o), 32'd1);
    check({e.name, "_pc_we"}, 32'(pc_write_en_o), 32'd1);
    check({e.name, "_rf_we"}, 32'(regfile_write_en_o), 32'(e.we));
    if (e.we) check({e.name, "_sel"}, 32'(regfile_addr_3_sel_o), 32'(e.sel));
    if (e.chk_rd) check({e.name, "_rd"}, rd_o, e.rd);
    if (e.chk_rt) check({e.name, "_rt"}, rt_o, e.rtv);
  endtask

  initial begin
    reset_i = 1'b1; halt_i = 1'b0; stall_i = 1'b0;
    opcode_i = '0; funct_i = '0; immediate_i = '0;
    rs_i = '0; rt_i = '0; ram_readdata_i = 32'hDEADBEEF;

    //           name     op     fn     imm      rs            rt            we sel crd rd            crt rt
    vecs.push_back('{"ADDIU", 6'h09, 6'h00, 16'h0001, 32'h7FFFFFFF, 32'h0,        1, 1, 0, 32'h0,        1, 32'h80000000});
    vecs.push_back('{"SLT",   6'h00, 6'h2A, 16'h0000, 32'hFFFFFFFF, 32'h1,        1, 0, 1, 32'h1,        0, 32'h0});
    vecs.push_back('{"SLTU",  6'h00, 6'h2B, 16'h0000, 32'hFFFFFFFF, 32'h1,        1, 0, 1, 32'h0,        0, 32'h0});
    vecs.push_back('{"MULTU", 6'h00, 6'h19, 16'h0000, 32'hFFFFFFFF, 32'h2,        0, 0, 0, 32'h0,        0, 32'h0});
    vecs.push_back('{"MFHI",  6'h00, 6'h10, 16'h0000, 32'h0,        32'h0,        1, 0, 1, 32'h1,        0, 32'h0});
    vecs.push_back('{"MFLO",  6'h00, 6'h12, 16'h0000, 32'h0,        32'h0,        1, 0, 1, 32'hFFFFFFFE, 0, 32'h0});
    vecs.push_back('{"MULT",  6'h00, 6'h18, 16'h0000, 32'hFFFFFFFF, 32'h2,        0, 0, 0, 32'h0,        0, 32'h0});
    vecs.push_back('{"MFHIs", 6'h00, 6'h10, 16'h0000, 32'h0,        32'h0,        1, 0, 1, 32'hFFFFFFFF, 0, 32'h0});
    vecs.push_back('{"MTLO",  6'h00, 6'h13, 16'h0000, 32'h12345678, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0});
    vecs.push_back('{"MFLOm", 6'h00, 6'h12, 16'h0000, 32'h0,        32'h0,        1, 0, 1, 32'h12345678, 0, 32'h0});
    vecs.push_back('{"SUBU",  6'h00, 6'h23, 16'h0000, 32'h0,        32'h1,        1, 0, 1, 32'hFFFFFFFF, 0, 32'h0});
    vecs.push_back('{"ADDU",  6'h00, 6'h21, 16'h0000, 32'hFFFFFFFF, 32'h2,        1, 0, 1, 32'h1,        0, 32'h0});
    vecs.push_back('{"SRA",   6'h00, 6'h03, 16'h0100, 32'h0,        32'h80000000, 1, 0, 1, 32'hF8000000, 0, 32'h0});
    vecs.push_back('{"SLL31", 6'h00, 6'h00, 16'h07C0, 32'h0,        32'h1,        1, 0, 1, 32'h80000000, 0, 32'h0});
    vecs.push_back('{"SRLV",  6'h00, 6'h06, 16'h0000, 32'h4,        32'h80000000, 1, 0, 1, 32'h08000000, 0, 32'h0});
    vecs.push_back('{"NOR",   6'h00, 6'h27, 16'h0000, 32'h0F0F0000, 32'h00F0000F, 1, 0, 1, 32'hF000FFF0, 0, 32'h0});
    vecs.push_back('{"SLTI",  6'h0A, 6'h00, 16'hFFFF, 32'hFFFFFFFE, 32'h0,        1, 1, 0, 32'h0,        1, 32'h1});
    vecs.push_back('{"SLTIU", 6'h0B, 6'h00, 16'hFFFF, 32'h5,        32'h0,        1, 1, 0, 32'h0,        1, 32'h1});
    vecs.push_back('{"ANDI",  6'h0C, 6'h00, 16'hF0F0, 32'hFFFF1234, 32'h0,        1, 1, 0, 32'h0,        1, 32'h00001030});
    vecs.push_back('{"LUI",   6'h0F, 6'h00, 16'hABCD, 32'h0,        32'h0,        1, 1, 0, 32'h0,        1, 32'hABCD0000});
    vecs.push_back('{"BADOP", 6'h3F, 6'h00, 16'h0000, 32'h0,        32'h0,        0, 0, 0, 32'h0,        0, 32'h0});
    vecs.push_back('{"BADFN", 6'h00, 6'h01, 16'h0000, 32'h0,        32'h0,        0, 0, 0, 32'h0,        0, 32'h0});

    // Reset state
    step(); step();
    reset_i = 1'b0;
    check("reset_state", 32'(state_o), 32'd0);
    check("reset_hi", mfhi_o, 32'h0);
    check("reset_lo", mflo_o, 32'h0);
    check("fetch_read", 32'(ram_read_en_o), 32'd1);
    check("fetch_ir_we", 32'(ir_write_en_o), 32'd1);
    check("fetch_byte_en", 32'(ram_byte_en_o), 32'hF);
    check("fetch_addr_sel", 32'(ram_addr_sel_o), 32'd0);

    // Stall in FETCH holds the state and masks the IR write
    stall_i = 1'b1;
    #1;
    check("fstall_ir_we", 32'(ir_write_en_o), 32'd0);
    check("fstall_read", 32'(ram_read_en_o), 32'd1);
    step();
    check("fstall_state", 32'(state_o), 32'd0);
    stall_i = 1'b0;

    // Table-driven single-instruction vectors
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      step();
      checkOutput();
      step();
      check({vecs[i].name, "_back_fetch"}, 32'(state_o), 32'd0);
    end
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    // Reset mid-instruction abandons a MULTU and clears HI/LO
    applyStimulus('{"MULTUrst", 6'h00, 6'h19, 16'h0, 32'hFFFFFFFF, 32'h3, 0, 0, 0, 32'h0, 0, 32'h0});
    step();
    checkOutput();
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    check("midrst_state", 32'(state_o), 32'd0);
    check("midrst_hi", mfhi_o, 32'h0);
    check("midrst_lo", mflo_o, 32'h0);

    // LW with a bus stall in EXEC, then MEM writes the load data
    opcode_i = 6'h23; funct_i = 6'h00; immediate_i = 16'hFFFC; rs_i = 32'h1000; rt_i = 32'h0;
    step();
    check("lw_state_exec", 32'(state_o), 32'd1);
    check("lw_ea", effective_address_o, 32'h00000FFC);
    check("lw_read", 32'(ram_read_en_o), 32'd1);
    check("lw_addr_sel", 32'(ram_addr_sel_o), 32'd1);
    check("lw_byte_en", 32'(ram_byte_en_o), 32'hF);
    check("lw_exec_rf_we", 32'(regfile_write_en_o), 32'd0);
    stall_i = 1'b1;
    #1;
    check("lw_stall_pc_we", 32'(pc_write_en_o), 32'd0);
    check("lw_stall_read", 32'(ram_read_en_o), 32'd1);
    step();
    check("lw_stall_state", 32'(state_o), 32'd1);
    stall_i = 1'b0;
    #1;
    check("lw_pc_we", 32'(pc_write_en_o), 32'd1);
    step();
    check("lw_state_mem", 32'(state_o), 32'd2);
    check("lw_mem_rt", rt_o, 32'hDEADBEEF);
    check("lw_mem_rf_we", 32'(regfile_write_en_o), 32'd1);
    check("lw_mem_sel", 32'(regfile_addr_3_sel_o), 32'd1);
    check("lw_mem_read", 32'(ram_read_en_o), 32'd0);
    step();
    check("lw_back_fetch", 32'(state_o), 32'd0);

    // SW drives the store data and a write request
    opcode_i = 6'h2B; immediate_i = 16'h0010; rs_i = 32'h2000; rt_i = 32'hCAFEF00D;
    step();
    check("sw_write", 32'(ram_write_en_o), 32'd1);
    check("sw_addr_sel", 32'(ram_addr_sel_o), 32'd1);
    check("sw_data", rt_o, 32'hCAFEF00D);
    check("sw_ea", effective_address_o, 32'h00002010);
    check("sw_rf_we", 32'(regfile_write_en_o), 32'd0);
    step();
    check("sw_back_fetch", 32'(state_o), 32'd0);

    // JR to address 0, then halt_i in FETCH leads to a permanent HALT
    opcode_i = 6'h00; funct_i = 6'h08; immediate_i = 16'h0; rs_i = 32'h0; rt_i = 32'h0;
    step();
    check("jr_b_cond", 32'(b_cond_met_o), 32'd1);
    check("jr_pc_we", 32'(pc_write_en_o), 32'd1);
    check("jr_rf_we", 32'(regfile_write_en_o), 32'd0);
    halt_i = 1'b1;
    step();
    check("halt_fetch_state", 32'(state_o), 32'd0);
    check("halt_fetch_read", 32'(ram_read_en_o), 32'd0);
    check("halt_fetch_ir_we", 32'(ir_write_en_o), 32'd0);
    check("halt_fetch_byte_en", 32'(ram_byte_en_o), 32'h0);
    step();
    check("halt_state", 32'(state_o), 32'd3);
    halt_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("halt_stays", 32'(state_o), 32'd3);
      check("halt_enables",
            32'({pc_write_en_o, ir_write_en_o, regfile_write_en_o, ram_read_en_o,
                 ram_write_en_o, b_cond_met_o, ram_byte_en_o}), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
